gnn_seq_ctrl: RTL and testbench
===============================

Name: gnn_seq_ctrl

Overview:
Sequencer for the two-layer GNN datapath: aggregation 1 -> dnn_layer1 (x4 nodes) -> aggregation 2 -> relu_4n -> dnn_layer2 (x4 nodes). It accepts a start request and issues a one-cycle in_ready/go pulse to each stage in order. It waits for that stage's ready/done level, guards every stage with a timeout, and reports done, error and measured latency. It sits beside gnn_top and drives the stage in_ready inputs, replacing the undriven top-level in_ready.

Parameters:
TIMEOUT, 64, max cycles counted in a stage (counter value) before declaring an error
TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2**TO_W
LAT_W, 12, width of the latency counter and of last_latency

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  run request; honoured only in IDLE
abort  input  1  return to IDLE from any non-IDLE state
result_ack  input  1  releases DONE
clear_err  input  1  releases ERR
aggr1_ready  input  1  aggregation 1 out_ready_aggr
mac_ready  input  4  dnn_layer1 mac_ready, nodes 3..0
aggr2_ready  input  1  aggregation 2 out_ready_aggr
relu_ready  input  1  relu_4n relu_ready
out_ready  input  8  dnn_layer2 mac_ready1/mac_ready0 per node, {n3..n0}
aggr1_go  output  1  in_ready pulse to aggregation 1
layer1_go  output  1  in_ready pulse to dnn_layer1 instances
aggr2_go  output  1  in_ready pulse to aggregation 2
relu_go  output  1  in_ready pulse to relu_4n
layer2_go  output  1  in_ready pulse to dnn_layer2 instances
busy  output  1  high in states AGGR1..L2
done  output  1  high throughout DONE
error  output  1  high throughout ERR
stage  output  3  current state code
err_stage  output  3  stage code that timed out
last_latency  output  LAT_W  cycles of the last successful run

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all go outputs, busy, done and error are 0; stage=0; err_stage=0; last_latency=0; counters cleared. Reset mid-run aborts with no done.
- State codes: IDLE=0, AGGR1=1, L1=2, AGGR2=3, RELU=4, L2=5, DONE=6, ERR=7.
- IDLE: start=1 -> AGGR1 next cycle. start is ignored in every other state.
- Stage states 1..5: the matching go output is 1 only in the first cycle in the state. It is registered, not combinational from inputs.
- Done condition per stage:
  - AGGR1: aggr1_ready
  - L1: &mac_ready
  - AGGR2: aggr2_ready
  - RELU: relu_ready
  - L2: &out_ready
- The done condition is sampled only from the second cycle in the state onward. A level present during the go cycle alone is ignored as stale.
- When done is sampled true, move to the next stage next cycle; L2 moves to DONE.
- Timeout counter: 0 in the first cycle of each stage, +1 per cycle. If the counter equals TIMEOUT and done is false, go to ERR next cycle with err_stage = current code. If done and timeout coincide, done wins.
- Latency counter: cleared on leaving IDLE, +1 each cycle in states 1..5, saturates at all-ones. Copied to last_latency on entry to DONE. last_latency is unchanged on error or abort.
- DONE: done=1 until result_ack=1, then IDLE next cycle. A new start is accepted only once back in IDLE.
- ERR: error=1 and err_stage held until clear_err=1, then IDLE; err_stage keeps its value until the next error or reset.
- abort=1 in states 1..7 -> IDLE next cycle. No done, no latency update, and no go pulse in that cycle. abort takes priority over done, timeout, result_ack and clear_err.
- Exactly one go output is high in any cycle, or none.

Test Plan:
1. Reset, then start=1 for one cycle; each stage's ready asserted in its 2nd cycle -> go pulses on cycles 1, 3, 5, 7, 9; DONE entered at cycle 11; last_latency=10; busy high for cycles 1..10.
2. Same as scenario 1 but relu_ready never asserted (TIMEOUT=64) -> 65 cycles in RELU, then ERR with err_stage=4 and error=1; clear_err -> IDLE; last_latency stays at its previous value.
3. In L1 with mac_ready=4'b0111 held for 20 cycles -> stays in L1; setting mac_ready=4'b1111 -> AGGR2 next cycle with a single aggr2_go pulse.
4. aggr1_ready high only during the aggr1_go cycle -> ignored, no advance; held high from the 2nd cycle -> advances to L1.
5. abort during AGGR2, done in the same cycle -> IDLE, done=0, no relu_go; start while busy -> ignored.
6. rst_n=0 mid-L2 -> all outputs at reset values next cycle; DONE held with result_ack=0 for 10 cycles -> done stays 1, start ignored; result_ack=1 -> IDLE.

Source files
------------

// File: rtl/gnn_seq_ctrl.sv
// Sequencer for the two-layer GNN datapath: pulses each stage's in_ready in order,
// waits for its ready level under a per-stage timeout, and reports done/error/latency.
module gnn_seq_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8,
    parameter int LAT_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             result_ack,
    input  logic             clear_err,
    input  logic             aggr1_ready,
    input  logic [3:0]       mac_ready,
    input  logic             aggr2_ready,
    input  logic             relu_ready,
    input  logic [7:0]       out_ready,
    output logic             aggr1_go,
    output logic             layer1_go,
    output logic             aggr2_go,
    output logic             relu_go,
    output logic             layer2_go,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       stage,
    output logic [2:0]       err_stage,
    output logic [LAT_W-1:0] last_latency
);

    // state | meaning
    // IDLE  | waiting for start
    // AGGR1 | aggregation 1 running
    // L1    | dnn_layer1 (4 nodes) running
    // AGGR2 | aggregation 2 running
    // RELU  | relu_4n running
    // L2    | dnn_layer2 (4 nodes) running
    // DONE  | run complete, waiting for result_ack
    // ERR   | stage timed out, waiting for clear_err
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_AGGR1 = 3'd1;
    localparam logic [2:0] S_L1    = 3'd2;
    localparam logic [2:0] S_AGGR2 = 3'd3;
    localparam logic [2:0] S_RELU  = 3'd4;
    localparam logic [2:0] S_L2    = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_inc;
    logic [4:0]       go_q;
    logic             in_stage;
    logic             armed;
    logic             cond;
    logic             timed_out;

    always_comb begin
        in_stage = (state >= S_AGGR1) && (state <= S_L2);
        // ready levels seen during the go cycle belong to a previous run
        armed    = (to_cnt != '0);
        lat_inc  = (&lat_cnt) ? lat_cnt : lat_cnt + 1'b1;
    end

    always_comb begin
        cond = 1'b0;
        case (state)
            S_AGGR1: cond = aggr1_ready;
            S_L1:    cond = &mac_ready;
            S_AGGR2: cond = aggr2_ready;
            S_RELU:  cond = relu_ready;
            S_L2:    cond = &out_ready;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        timed_out = (to_cnt == TO_LIMIT);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_AGGR1;
                end
            end
            S_AGGR1, S_L1, S_AGGR2, S_RELU, S_L2: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (armed && cond) begin
                    state_nxt = state + 3'd1;
                end else if (timed_out) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                if (abort || result_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                if (abort || clear_err) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!in_stage || (state_nxt != state)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_cnt <= '0;
        end else if (state == S_IDLE) begin
            lat_cnt <= '0;
        end else if (in_stage) begin
            lat_cnt <= lat_inc;
        end
    end

    // L2's final cycle is included, hence the incremented value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_latency <= '0;
        end else if ((state == S_L2) && (state_nxt == S_DONE)) begin
            last_latency <= lat_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_stage <= 3'd0;
        end else if ((state_nxt == S_ERR) && (state != S_ERR)) begin
            err_stage <= state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            go_q <= '0;
        end else begin
            go_q <= '0;
            if (state_nxt != state) begin
                case (state_nxt)
                    S_AGGR1: go_q[0] <= 1'b1;
                    S_L1:    go_q[1] <= 1'b1;
                    S_AGGR2: go_q[2] <= 1'b1;
                    S_RELU:  go_q[3] <= 1'b1;
                    S_L2:    go_q[4] <= 1'b1;
                    default: go_q    <= '0;
                endcase
            end
        end
    end

    always_comb begin
        aggr1_go  = go_q[0];
        layer1_go = go_q[1];
        aggr2_go  = go_q[2];
        relu_go   = go_q[3];
        layer2_go = go_q[4];
        busy      = in_stage;
        done      = (state == S_DONE);
        error     = (state == S_ERR);
        stage     = state;
    end

endmodule

// File: tb/tb_gnn_seq_ctrl.sv
// Scoreboarded bench for gnn_seq_ctrl: expected go pulses are queued as each run is
// launched and matched by a negedge monitor; state/status checks are directed.
module tb_gnn_seq_ctrl;

    localparam int LAT_W = 12;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             result_ack;
    logic             clear_err;
    logic             aggr1_ready;
    logic [3:0]       mac_ready;
    logic             aggr2_ready;
    logic             relu_ready;
    logic [7:0]       out_ready;
    logic             aggr1_go;
    logic             layer1_go;
    logic             aggr2_go;
    logic             relu_go;
    logic             layer2_go;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       stage;
    logic [2:0]       err_stage;
    logic [LAT_W-1:0] last_latency;

    gnn_seq_ctrl #(.TIMEOUT(64), .TO_W(8), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .result_ack(result_ack), .clear_err(clear_err),
        .aggr1_ready(aggr1_ready), .mac_ready(mac_ready), .aggr2_ready(aggr2_ready),
        .relu_ready(relu_ready), .out_ready(out_ready),
        .aggr1_go(aggr1_go), .layer1_go(layer1_go), .aggr2_go(aggr2_go),
        .relu_go(relu_go), .layer2_go(layer2_go),
        .busy(busy), .done(done), .error(error), .stage(stage),
        .err_stage(err_stage), .last_latency(last_latency)
    );

    typedef struct {
        logic [4:0] go;
        int         cyc;
    } go_exp_t;

    go_exp_t q[$];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_go(input int idx, input int exp_cyc);
        go_exp_t e;
        e.go  = 5'b00001 << idx;
        e.cyc = exp_cyc;
        q.push_back(e);
    endtask

    task automatic set_ready(input int s, input logic v);
        case (s)
            1: aggr1_ready = v;
            2: mac_ready   = v ? 4'hf : 4'h0;
            3: aggr2_ready = v;
            4: relu_ready  = v;
            5: out_ready   = v ? 8'hff : 8'h00;
            default: ;
        endcase
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // from the go cycle of stage s: assert ready in the 2nd cycle, land in stage s+1
    task automatic pass_stage(input int s);
        tick();
        set_ready(s, 1'b1);
        tick();
        set_ready(s, 1'b0);
    endtask

    // go monitor: every go pulse must match the head of the scoreboard
    always @(negedge clk) begin
        logic [4:0] gv;
        go_exp_t    e;
        gv = {layer2_go, relu_go, aggr2_go, layer1_go, aggr1_go};
        if (busy === 1'b1) busy_cnt++;
        if (gv != 5'b0) begin
            chk("go_onehot", 32'($onehot(gv)), 32'd1);
            if (q.size() == 0) begin
                chk("go_unexpected", 32'(gv), 32'd0);
            end else begin
                e = q.pop_front();
                chk("go_vec", 32'(gv), 32'(e.go));
                if (e.cyc >= 0) chk("go_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ack = 1'b0; clear_err = 1'b0;
        aggr1_ready = 1'b0; mac_ready = 4'h0; aggr2_ready = 1'b0; relu_ready = 1'b0;
        out_ready = 8'h00;
        tick();
        tick();
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_stage", 32'(err_stage), 32'd0);
        chk("rst_last_lat", 32'(last_latency), 32'd0);
        chk("rst_go", 32'({layer2_go, relu_go, aggr2_go, layer1_go, aggr1_go}), 32'd0);
        rst_n = 1'b1;
        tick();

        // nominal run, go pulses at cycles 1,3,5,7,9
        base = cyc;
        for (int i = 0; i < 5; i++) push_go(i, base + 1 + 2 * i);
        busy_cnt = 0;
        start_run();
        chk("s1_stage_aggr1", 32'(stage), 32'd1);
        for (int s = 1; s <= 5; s++) pass_stage(s);
        chk("s1_stage_done", 32'(stage), 32'd6);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_busy", 32'(busy), 32'd0);
        chk("s1_done_cycle", cyc - base, 32'd11);
        chk("s1_last_lat", 32'(last_latency), 32'd10);
        chk("s1_busy_cycles", busy_cnt, 32'd10);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("s1_idle", 32'(stage), 32'd0);

        // relu never ready: timeout
        for (int i = 0; i < 4; i++) push_go(i, -1);
        start_run();
        for (int s = 1; s <= 3; s++) pass_stage(s);
        chk("s2_in_relu", 32'(stage), 32'd4);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (stage != 3'd4) break;
            n++;
        end
        chk("s2_relu_cycles", n, 32'd65);
        chk("s2_err_state", 32'(stage), 32'd7);
        chk("s2_error", 32'(error), 32'd1);
        chk("s2_err_stage", 32'(err_stage), 32'd4);
        chk("s2_last_lat", 32'(last_latency), 32'd10);
        tick();
        tick();
        chk("s2_error_held", 32'(error), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("s2_idle", 32'(stage), 32'd0);
        chk("s2_error_clr", 32'(error), 32'd0);
        chk("s2_err_stage_kept", 32'(err_stage), 32'd4);

        // partial mac_ready holds L1; start while busy ignored
        for (int i = 0; i < 3; i++) push_go(i, -1);
        start_run();
        pass_stage(1);
        mac_ready = 4'b0111;
        for (int k = 0; k < 20; k++) begin
            start = k[0];
            tick();
        end
        start = 1'b0;
        chk("s3_held_l1", 32'(stage), 32'd2);
        chk("s3_no_error", 32'(error), 32'd0);
        mac_ready = 4'b1111;
        tick();
        mac_ready = 4'b0000;
        chk("s3_aggr2", 32'(stage), 32'd3);
        chk("s3_aggr2_go", 32'(aggr2_go), 32'd1);

        // abort wins over a coincident done in AGGR2
        tick();
        aggr2_ready = 1'b1;
        abort = 1'b1;
        tick();
        aggr2_ready = 1'b0;
        abort = 1'b0;
        chk("s5_idle", 32'(stage), 32'd0);
        chk("s5_done", 32'(done), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_last_lat", 32'(last_latency), 32'd10);
        tick();
        tick();
        chk("s5_stay_idle", 32'(stage), 32'd0);

        // stale aggr1_ready in go cycle is ignored
        push_go(0, -1);
        push_go(1, -1);
        start_run();
        aggr1_ready = 1'b1;
        tick();
        aggr1_ready = 1'b0;
        chk("s4_stale_ignored", 32'(stage), 32'd1);
        tick();
        tick();
        chk("s4_still_aggr1", 32'(stage), 32'd1);
        aggr1_ready = 1'b1;
        tick();
        aggr1_ready = 1'b0;
        chk("s4_to_l1", 32'(stage), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_abort_idle", 32'(stage), 32'd0);

        // reset mid-L2
        for (int i = 0; i < 5; i++) push_go(i, -1);
        start_run();
        for (int s = 1; s <= 4; s++) pass_stage(s);
        chk("s6_in_l2", 32'(stage), 32'd5);
        tick();
        rst_n = 1'b0;
        tick();
        chk("s6_rst_stage", 32'(stage), 32'd0);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_done", 32'(done), 32'd0);
        chk("s6_rst_err_stage", 32'(err_stage), 32'd0);
        chk("s6_rst_last_lat", 32'(last_latency), 32'd0);
        rst_n = 1'b1;
        tick();

        // DONE held without result_ack
        for (int i = 0; i < 5; i++) push_go(i, -1);
        start_run();
        for (int s = 1; s <= 5; s++) pass_stage(s);
        for (int k = 0; k < 10; k++) begin
            start = 1'b1;
            tick();
            chk("s6_done_held", 32'(done), 32'd1);
        end
        start = 1'b0;
        chk("s6_stage_done", 32'(stage), 32'd6);
        chk("s6_last_lat", 32'(last_latency), 32'd10);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("s6_idle", 32'(stage), 32'd0);
        chk("s6_done_clr", 32'(done), 32'd0);
        tick();
        tick();

        chk("go_queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
